// File: rtl/dmem_access_fsm.sv
// dmem_access_fsm
// Multicycle data-memory access sequencer. Accepts one load/store at a time,
// rejects misaligned or illegal-size requests without touching the bus, drives
// a valid/ready bus transaction with word address, byte strobes and
// lane-replicated store data, and returns the raw read word with the low
// address bits and error flags as a one-cycle response.
module dmem_access_fsm #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMO_W          = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_addr_lo,
  output logic        rsp_misaligned,
  output logic        rsp_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Last counter value still allowed before the bus cycle is abandoned.
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_addr_lo_q, rsp_addr_lo_d;
  logic             rsp_mis_q, rsp_mis_d;
  logic             rsp_tmo_q, rsp_tmo_d;

  logic             req_misaligned;
  logic [3:0]       req_strb;
  logic [31:0]      req_lanes;

  // Natural-alignment check and illegal-size detection for the incoming request.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  // Byte strobes and lane-replicated store data derived from size and offset.
  always_comb begin
    req_strb  = 4'b0000;
    req_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        req_strb  = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_strb  = 4'b0011 << req_addr[1:0];
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_strb  = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
  end

  // Next-state, timeout counter and datapath register updates.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_load_d     = is_load_q;
    addr_lo_d     = addr_lo_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_addr_lo_d = rsp_addr_lo_q;
    rsp_mis_d     = rsp_mis_q;
    rsp_tmo_d     = rsp_tmo_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          if (req_misaligned) begin
            state_d       = ST_RESP;
            rsp_rdata_d   = 32'h0;
            rsp_addr_lo_d = req_addr[1:0];
            rsp_mis_d     = 1'b1;
            rsp_tmo_d     = 1'b0;
          end else begin
            state_d     = ST_BUS;
            is_load_d   = ~req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = req_we ? req_strb : 4'b0000;
            mem_wdata_d = req_we ? req_lanes : 32'h0;
          end
        end
      end

      ST_BUS: begin
        if (mem_ready) begin
          state_d       = ST_RESP;
          cnt_d         = '0;
          rsp_rdata_d   = is_load_q ? mem_rdata : 32'h0;
          rsp_addr_lo_d = addr_lo_q;
          rsp_mis_d     = 1'b0;
          rsp_tmo_d     = 1'b0;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d       = ST_RESP;
          cnt_d         = '0;
          rsp_rdata_d   = 32'h0;
          rsp_addr_lo_d = addr_lo_q;
          rsp_mis_d     = 1'b0;
          rsp_tmo_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_load_q     <= 1'b0;
      addr_lo_q     <= 2'b00;
      mem_addr_q    <= 32'h0;
      mem_wstrb_q   <= 4'b0000;
      mem_wdata_q   <= 32'h0;
      rsp_rdata_q   <= 32'h0;
      rsp_addr_lo_q <= 2'b00;
      rsp_mis_q     <= 1'b0;
      rsp_tmo_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_load_q     <= is_load_d;
      addr_lo_q     <= addr_lo_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_addr_lo_q <= rsp_addr_lo_d;
      rsp_mis_q     <= rsp_mis_d;
      rsp_tmo_q     <= rsp_tmo_d;
    end
  end

  // Handshake outputs are pure state decodes; data outputs come from registers.
  always_comb begin
    req_ready      = (state_q == ST_IDLE);
    mem_valid      = (state_q == ST_BUS);
    rsp_valid      = (state_q == ST_RESP);
    mem_addr       = mem_addr_q;
    mem_wstrb      = mem_wstrb_q;
    mem_wdata      = mem_wdata_q;
    rsp_rdata      = rsp_rdata_q;
    rsp_addr_lo    = rsp_addr_lo_q;
    rsp_misaligned = rsp_mis_q;
    rsp_timeout    = rsp_tmo_q;
  end

endmodule

// File: tb/tb_dmem_access_fsm.sv
// tb_dmem_access_fsm
// Drives directed and randomized load/store transactions, with random bus wait
// states and read data, against dmem_access_fsm. A transaction-level model
// predicts every cycle's outputs from the request and the chosen wait count.
module tb_dmem_access_fsm;

  localparam int TMO = 8;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_addr_lo;
  logic        rsp_misaligned;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs, written by the stimulus, read by the comparator.
  logic        chkEn;
  logic        expReqReady;
  logic        expMemValid;
  logic [31:0] expMemAddr;
  logic [3:0]  expStrb;
  logic [31:0] expWdata;
  logic        expRspValid;
  logic [31:0] expRspRdata;
  logic [1:0]  expRspAddrLo;
  logic        expRspMis;
  logic        expRspTmo;

  // Observations gathered for the directed literal checks.
  int          cyc = 0;
  int          acceptCyc = 0;
  int          rspCyc = 0;
  int          memValidCnt = 0;
  logic [31:0] obsAddr;
  logic [3:0]  obsStrb;
  logic [31:0] obsWdata;

  dmem_access_fsm #(
    .TIMEOUT_CYCLES(TMO),
    .TMO_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_addr_lo(rsp_addr_lo),
    .rsp_misaligned(rsp_misaligned),
    .rsp_timeout(rsp_timeout)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison helper: counts, and reports one line on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Comparator: checks the DUT against the model on every falling edge.
  always @(negedge clk) begin
    cyc++;
    if (chkEn) begin
      checkOutput("req_ready", 32'(req_ready), 32'(expReqReady));
      checkOutput("mem_valid", 32'(mem_valid), 32'(expMemValid));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRspValid));
      checkOutput("rsp_rdata", rsp_rdata, expRspRdata);
      checkOutput("rsp_addr_lo", 32'(rsp_addr_lo), 32'(expRspAddrLo));
      checkOutput("rsp_misaligned", 32'(rsp_misaligned), 32'(expRspMis));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(expRspTmo));
      if (expMemValid) begin
        checkOutput("mem_addr", mem_addr, expMemAddr);
        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(expStrb));
        checkOutput("mem_wdata", mem_wdata, expWdata);
      end
    end
    if (req_valid && req_ready) acceptCyc = cyc;
    if (rsp_valid) rspCyc = cyc;
    if (mem_valid) begin
      memValidCnt++;
      obsAddr  = mem_addr;
      obsStrb  = mem_wstrb;
      obsWdata = mem_wdata;
    end
  end

  // One complete transaction: drives request and bus, and predicts each cycle.
  // Called just after a rising edge while the DUT is idle. delay is the number
  // of wait cycles before mem_ready; anything >= TMO never sees ready in time.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                               input int gap);
    int   bytes;
    int   lo;
    int   busCycles;
    logic mis;
    logic tmo;
    logic [3:0]  strb;
    logic [31:0] lanes;

    lo    = int'(addr[1:0]);
    bytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis   = (size == 2'b11) || ((lo % bytes) != 0);
    strb  = 4'b0000;
    lanes = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (we && (i >= lo) && (i < lo + bytes)) strb[i] = 1'b1;
      if (we) lanes[8*i +: 8] = wdata[8*(i % bytes) +: 8];
    end
    tmo       = !mis && (delay >= TMO);
    busCycles = mis ? 0 : (tmo ? TMO : delay + 1);
    memValidCnt = 0;

    // Accept cycle
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    expReqReady = 1'b1;
    expMemValid = 1'b0;
    expRspValid = 1'b0;
    @(posedge clk); #1;

    // Bus cycles, with junk on the request side that must be ignored
    for (int k = 0; k < busCycles; k++) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      expReqReady = 1'b0;
      expMemValid = 1'b1;
      expMemAddr  = {addr[31:2], 2'b00};
      expStrb     = strb;
      expWdata    = lanes;
      expRspValid = 1'b0;
      @(posedge clk); #1;
    end

    // Response cycle
    req_valid    = 1'b0;
    mem_ready    = 1'($urandom);
    mem_rdata    = $urandom;
    expReqReady  = 1'b0;
    expMemValid  = 1'b0;
    expRspValid  = 1'b1;
    expRspRdata  = (!mis && !tmo && !we) ? rdata : 32'h0;
    expRspAddrLo = addr[1:0];
    expRspMis    = mis;
    expRspTmo    = tmo;
    @(posedge clk); #1;

    // Back in idle; response fields hold
    mem_ready   = 1'b0;
    expReqReady = 1'b1;
    expMemValid = 1'b0;
    expRspValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic setResetExpect();
    expReqReady  = 1'b1;
    expMemValid  = 1'b0;
    expMemAddr   = 32'h0;
    expStrb      = 4'b0000;
    expWdata     = 32'h0;
    expRspValid  = 1'b0;
    expRspRdata  = 32'h0;
    expRspAddrLo = 2'b00;
    expRspMis    = 1'b0;
    expRspTmo    = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    setResetExpect();
    chkEn = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Aligned load, immediate ready
    applyStimulus(1'b0, 2'b10, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, 1);
    checkOutput("lw mem_addr", obsAddr, 32'h0000_0104);
    checkOutput("lw wstrb", 32'(obsStrb), 32'h0);
    checkOutput("lw latency", 32'(rspCyc - acceptCyc), 32'd2);
    checkOutput("lw rdata", rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("lw addr_lo", 32'(rsp_addr_lo), 32'h0);

    // Byte store to lane 3
    applyStimulus(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 0, 32'h1234_5678, 0);
    checkOutput("sb mem_addr", obsAddr, 32'h0000_0200);
    checkOutput("sb wstrb", 32'(obsStrb), 32'h8);
    checkOutput("sb wdata", obsWdata, 32'hA5A5_A5A5);
    checkOutput("sb rdata", rsp_rdata, 32'h0);

    // Misaligned half and word loads never reach the bus
    applyStimulus(1'b0, 2'b01, 32'h0000_0011, 32'h0, 0, 32'hFFFF_FFFF, 0);
    checkOutput("lh mis bus cycles", 32'(memValidCnt), 32'd0);
    checkOutput("lh mis latency", 32'(rspCyc - acceptCyc), 32'd1);
    checkOutput("lh mis flag", 32'(rsp_misaligned), 32'h1);
    checkOutput("lh mis addr_lo", 32'(rsp_addr_lo), 32'h1);
    applyStimulus(1'b0, 2'b10, 32'h0000_0012, 32'h0, 0, 32'hFFFF_FFFF, 2);
    checkOutput("lw mis bus cycles", 32'(memValidCnt), 32'd0);
    checkOutput("lw mis addr_lo", 32'(rsp_addr_lo), 32'h2);

    // Half store with five wait states
    applyStimulus(1'b1, 2'b01, 32'h0000_0042, 32'h1234_BEEF, 5, 32'h0, 0);
    checkOutput("sh valid cycles", 32'(memValidCnt), 32'd6);
    checkOutput("sh wstrb", 32'(obsStrb), 32'hC);
    checkOutput("sh wdata", obsWdata, 32'hBEEF_BEEF);
    checkOutput("sh latency", 32'(rspCyc - acceptCyc), 32'd7);

    // Timeout with no ready, then ready on the last allowed cycle
    applyStimulus(1'b0, 2'b10, 32'h0000_0080, 32'h0, 1000, 32'h5555_AAAA, 0);
    checkOutput("tmo valid cycles", 32'(memValidCnt), 32'd8);
    checkOutput("tmo flag", 32'(rsp_timeout), 32'h1);
    checkOutput("tmo rdata", rsp_rdata, 32'h0);
    applyStimulus(1'b0, 2'b10, 32'h0000_0084, 32'h0, TMO - 1, 32'h5555_AAAA, 0);
    checkOutput("edge valid cycles", 32'(memValidCnt), 32'd8);
    checkOutput("edge flag", 32'(rsp_timeout), 32'h0);
    checkOutput("edge rdata", rsp_rdata, 32'h5555_AAAA);

    // Asynchronous reset while the bus cycle is outstanding
    chkEn     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0300;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("pre-reset mem_valid", 32'(mem_valid), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async mem_valid", 32'(mem_valid), 32'h0);
    checkOutput("async req_ready", 32'(req_ready), 32'h1);
    setResetExpect();
    chkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b10, 32'h0000_0304, 32'h0, 2, 32'hCAFE_F00D, 0);
    checkOutput("post-reset rdata", rsp_rdata, 32'hCAFE_F00D);
    checkOutput("post-reset latency", 32'(rspCyc - acceptCyc), 32'd4);

    // Randomized traffic, including illegal sizes and timeouts
    for (int t = 0; t < 250; t++) begin
      applyStimulus(1'($urandom), 2'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_fsm.md
Name: dmem_access_fsm

Overview:
- Multicycle data-memory access sequencer between the core's load/store control and the data bus.
- Accepts one load/store request at a time and checks natural alignment.
- Builds word-aligned bus address, byte strobes and lane-replicated store data; runs the valid/ready bus handshake.
- Returns the raw 32-bit read word plus addr[1:0] to the downstream load-alignment/sign-extension stage, with error flags.

Parameters:
- TIMEOUT_CYCLES, 0: bus cycles without mem_ready before abort; 0 disables the timeout.
- TMO_W, 16: timeout counter width; TIMEOUT_CYCLES < 2^TMO_W.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, sampled when mem_valid & mem_ready
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  captured raw word; 0 for stores and errors
- rsp_addr_lo  out  2  req_addr[1:0] of the completed request
- rsp_misaligned  out  1  alignment or illegal-size error
- rsp_timeout  out  1  bus timeout abort

Behaviour:
- Reset (resetn low, async): state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
- All outputs are registered or state-decoded; no combinational path from req_* or mem_ready to any output.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> RESP with rsp_misaligned=1. No bus cycle issued.
  - Otherwise -> BUS.
- BUS:
  - mem_valid=1; mem_addr/mem_wstrb/mem_wdata stay stable until completion.
  - mem_ready=1 -> capture mem_rdata (loads only), go to RESP.
  - No ready: counter increments. When TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with no ready -> RESP with rsp_timeout=1, mem_valid deasserts.
  - mem_ready in the same cycle as the timeout boundary: the ready wins, no timeout.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Counter clears.
  - rsp_* fields hold their values until the next RESP.
- Strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0] (addr[1:0] is 00 or 10)
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Latency:
  - Accept at cycle 0; mem_valid at cycle 1.
  - With mem_ready at cycle 1+N, rsp_valid at cycle 2+N.
  - Misaligned request: rsp_valid at cycle 1.
- Throughput: one request per 3+N cycles. req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Reset mid-BUS: mem_valid drops immediately (async); no response is produced.

Test Plan:
- Aligned load: LW addr 0x104, mem_ready at cycle 1 with rdata 0xDEADBEEF -> mem_addr 0x104, wstrb 0000; rsp_valid at cycle 2, rsp_rdata 0xDEADBEEF, rsp_addr_lo 00.
- Byte store: SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5; rsp_rdata 0.
- Misaligned: LH addr 0x11 and LW addr 0x12 -> no mem_valid pulse; rsp_valid at cycle 1, rsp_misaligned=1, rsp_addr_lo 01 / 10.
- Wait states: SH addr 0x42 with mem_ready delayed 5 cycles -> mem_valid high 6 cycles, wstrb 1100, wdata {2{h}} stable throughout; rsp_valid at cycle 7.
- Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_valid high 8 cycles, rsp_timeout=1, rsp_rdata 0. Repeat with ready on the 8th cycle -> normal completion, no timeout.
- Async reset: resetn low while in BUS -> mem_valid low same cycle; req_ready=1 after release; next LW completes normally.
